audio_play_demux: RTL and testbench

- Playback-direction counterpart of the host capture path.
- Host (JACK side) writes left/right samples over the same Avalon-MM-style slave port into two internal sample FIFOs.
- The block drains one L/R pair per I2S frame (rising edge of lrck) toward the DAC/I2S transmitter.
- It reports fill level, overflow and underflow to the host, and raises a refill request below a programmable threshold.

---
 rtl/audio_play_pkg.sv | 30 +++
 rtl/sample_fifo.sv | 63 ++++++
 rtl/syncro_2.sv | 21 ++
 rtl/audio_play_demux.sv | 178 +++++++++++++++++
 tb/tb_audio_play_demux.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_play_pkg.sv
// Shared register map, control/status bit positions and tick classification
// for the playback demultiplexer.
package audio_play_pkg;

  localparam logic [2:0] ADDR_L      = 3'd0;
  localparam logic [2:0] ADDR_R      = 3'd1;
  localparam logic [2:0] ADDR_CTRL   = 3'd2;
  localparam logic [2:0] ADDR_THRESH = 3'd3;
  localparam logic [2:0] ADDR_STAT_L = 3'd4;
  localparam logic [2:0] ADDR_STAT_R = 3'd5;

  localparam int unsigned CTRL_EN_BIT    = 0;
  localparam int unsigned CTRL_FLUSH_BIT = 1;
  localparam int unsigned STAT_OVF_BIT   = 15;

  localparam logic [15:0] UNDERFLOW_MAX = 16'hFFFF;

  // What a frame tick does this cycle.
  typedef enum logic [1:0] {
    TICK_NONE,
    TICK_PLAY,
    TICK_UNDER,
    TICK_MUTE
  } tick_act_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == UNDERFLOW_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Single-clock sample FIFO with synchronous flush; level counts 0..depth and
// a push into a full FIFO is accepted only when a pop frees a slot that cycle.
module sample_fifo #(
  parameter int unsigned WIDTH      = 24,
  parameter int unsigned DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   ONE_L    = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] ONE_P    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full  = (level == FULL_LVL);
  assign empty = (level == '0);
  assign dout  = mem[rd_ptr];

  always_comb begin
    do_pop  = pop && !empty && !flush;
    do_push = push && !flush && (!full || do_pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ONE_P;
      if (do_pop)  rd_ptr <= rd_ptr + ONE_P;
      case ({do_push, do_pop})
        2'b10:   level <= level + ONE_L;
        2'b01:   level <= level - ONE_L;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/syncro_2.sv
// Two-flop synchroniser for a single asynchronous level signal.
module syncro_2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/audio_play_demux.sv
// Host-to-DAC playback path: register-mapped L/R sample FIFOs drained one
// pair per lrck frame, with level/overflow/underflow status and refill request.
module audio_play_demux
  import audio_play_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH    = 6,
  parameter int unsigned AUD_BIT_DEPTH = 24
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [2:0]               address,
  input  logic                     read,
  input  logic                     write,
  input  logic [31:0]              datain,
  output logic [31:0]              dataout,
  input  logic                     lrck,
  output logic [AUD_BIT_DEPTH-1:0] lsound_out,
  output logic [AUD_BIT_DEPTH-1:0] rsound_out,
  output logic                     sample_valid,
  output logic                     fill_req
);

  logic                     lrck_s;
  logic                     lrck_d;
  logic                     tick;
  logic                     enable;
  logic [FIFO_WIDTH:0]      threshold;
  logic                     overflow;
  logic [15:0]              underflow_cnt;

  logic                     wr_l, wr_r, wr_ctrl, wr_thr, flush;
  logic                     pop;
  logic                     ovf_set;
  tick_act_t                act;
  logic [AUD_BIT_DEPTH-1:0] sample_in;
  logic [AUD_BIT_DEPTH-1:0] l_head, r_head;
  logic [FIFO_WIDTH:0]      l_level, r_level;
  logic                     l_full, r_full, l_empty, r_empty;
  logic [31:0]              stat_l, stat_r;
  logic                     datain_unused;

  assign datain_unused = ^datain;

  syncro_2 u_lrck_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (lrck),
    .q       (lrck_s)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lrck_d <= 1'b0;
    else          lrck_d <= lrck_s;
  end

  assign tick = lrck_s && !lrck_d;

  always_comb begin
    wr_l      = write && (address == ADDR_L);
    wr_r      = write && (address == ADDR_R);
    wr_ctrl   = write && (address == ADDR_CTRL);
    wr_thr    = write && (address == ADDR_THRESH);
    flush     = wr_ctrl && datain[CTRL_FLUSH_BIT];
    sample_in = datain[31 -: AUD_BIT_DEPTH];
  end

  // A flush cycle swallows any coincident tick so outputs hold until the next one.
  always_comb begin
    act = TICK_NONE;
    if (tick && !flush) begin
      if (!enable)                 act = TICK_MUTE;
      else if (!l_empty && !r_empty) act = TICK_PLAY;
      else                         act = TICK_UNDER;
    end
  end

  assign pop     = (act == TICK_PLAY);
  assign ovf_set = (wr_l && l_full && !pop) || (wr_r && r_full && !pop);

  sample_fifo #(
    .WIDTH      (AUD_BIT_DEPTH),
    .DEPTH_LOG2 (FIFO_WIDTH)
  ) u_fifo_l (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (wr_l),
    .pop     (pop),
    .flush   (flush),
    .din     (sample_in),
    .dout    (l_head),
    .level   (l_level),
    .full    (l_full),
    .empty   (l_empty)
  );

  sample_fifo #(
    .WIDTH      (AUD_BIT_DEPTH),
    .DEPTH_LOG2 (FIFO_WIDTH)
  ) u_fifo_r (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (wr_r),
    .pop     (pop),
    .flush   (flush),
    .din     (sample_in),
    .dout    (r_head),
    .level   (r_level),
    .full    (r_full),
    .empty   (r_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable        <= 1'b0;
      threshold     <= '0;
      overflow      <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      if (wr_ctrl) enable    <= datain[CTRL_EN_BIT];
      if (wr_thr)  threshold <= datain[FIFO_WIDTH:0];
      if (flush) begin
        overflow      <= 1'b0;
        underflow_cnt <= '0;
      end else begin
        if (ovf_set)            overflow      <= 1'b1;
        if (act == TICK_UNDER)  underflow_cnt <= sat_inc16(underflow_cnt);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lsound_out   <= '0;
      rsound_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= (act == TICK_PLAY) || (act == TICK_UNDER);
      case (act)
        TICK_PLAY: begin
          lsound_out <= l_head;
          rsound_out <= r_head;
        end
        TICK_UNDER, TICK_MUTE: begin
          lsound_out <= '0;
          rsound_out <= '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fill_req <= 1'b0;
    else          fill_req <= enable && (l_level < threshold);
  end

  always_comb begin
    stat_l                  = '0;
    stat_l[31:16]           = underflow_cnt;
    stat_l[STAT_OVF_BIT]    = overflow;
    stat_l[FIFO_WIDTH:0]    = l_level;
    stat_r                  = '0;
    stat_r[FIFO_WIDTH:0]    = r_level;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dataout <= '0;
    end else if (read) begin
      case (address)
        ADDR_STAT_L: dataout <= stat_l;
        ADDR_STAT_R: dataout <= stat_r;
        default:     dataout <= dataout;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_play_demux.sv
// Self-checking bench for audio_play_demux: directed vector table, hand-built
// corner sequences and a randomized run against a queue-based model.
module tb_audio_play_demux;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] datain = '0;
  logic [31:0] dataout;
  logic        lrck = 1'b0;
  logic [23:0] lsound_out;
  logic [23:0] rsound_out;
  logic        sample_valid;
  logic        fill_req;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  audio_play_demux #(
    .FIFO_WIDTH    (6),
    .AUD_BIT_DEPTH (24)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .address      (address),
    .read         (read),
    .write        (write),
    .datain       (datain),
    .dataout      (dataout),
    .lrck         (lrck),
    .lsound_out   (lsound_out),
    .rsound_out   (rsound_out),
    .sample_valid (sample_valid),
    .fill_req     (fill_req)
  );

  typedef struct {
    int          kind;   // 0 write, 1 read+check, 2 frame+check
    logic [2:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t vq[$];

  // reference model state
  logic [23:0] lq[$];
  logic [23:0] rq[$];
  bit          men;
  bit          movf;
  logic [15:0] muf;
  logic [6:0]  mthr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    write = 1'b1; address = a; datain = d;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    read = 1'b1; address = a;
    @(negedge clk);
    read = 1'b0;
    d = dataout;
  endtask

  task automatic frame(output bit seen, output logic [23:0] l, output logic [23:0] r);
    seen = 1'b0; l = '0; r = '0;
    lrck = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (sample_valid && !seen) begin
        seen = 1'b1; l = lsound_out; r = rsound_out;
      end
    end
    lrck = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; lrck = 1'b0; write = 1'b0; read = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    lq.delete(); rq.delete();
    men = 0; movf = 0; muf = '0; mthr = '0;
  endtask

  function automatic logic [31:0] model_stat_l();
    return {muf, movf, 15'(lq.size())};
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit          seen;
    logic [23:0] l, r;
    logic [31:0] d;

    @(negedge clk);
    do_reset();
    chk("reset_dataout", dataout, 32'h0);
    chk("reset_lsound", {8'h0, lsound_out}, 32'h0);
    chk("reset_rsound", {8'h0, rsound_out}, 32'h0);
    chk("reset_valid", {31'h0, sample_valid}, 32'h0);
    chk("reset_fill_req", {31'h0, fill_req}, 32'h0);

    // Directed vectors: single pair playback, underflow frames, L-only underflow.
    vq.push_back('{0, 3'd2, 32'h0000_0001, 32'h0, 32'h0});
    vq.push_back('{0, 3'd0, 32'h1234_5600, 32'h0, 32'h0});
    vq.push_back('{0, 3'd1, 32'h6543_2100, 32'h0, 32'h0});
    vq.push_back('{1, 3'd4, 32'h0, 32'h0000_0001, 32'h0});
    vq.push_back('{1, 3'd5, 32'h0, 32'h0000_0001, 32'h0});
    vq.push_back('{2, 3'd0, 32'h0, 32'h0012_3456, 32'h0065_4321});
    vq.push_back('{1, 3'd4, 32'h0, 32'h0000_0000, 32'h0});
    vq.push_back('{2, 3'd0, 32'h0, 32'h0, 32'h0});
    vq.push_back('{2, 3'd0, 32'h0, 32'h0, 32'h0});
    vq.push_back('{2, 3'd0, 32'h0, 32'h0, 32'h0});
    vq.push_back('{1, 3'd4, 32'h0, 32'h0003_0000, 32'h0});
    vq.push_back('{0, 3'd2, 32'h0000_0003, 32'h0, 32'h0});
    vq.push_back('{0, 3'd0, 32'h1111_1100, 32'h0, 32'h0});
    vq.push_back('{0, 3'd0, 32'h2222_2200, 32'h0, 32'h0});
    vq.push_back('{0, 3'd0, 32'h3333_3300, 32'h0, 32'h0});
    vq.push_back('{0, 3'd0, 32'h4444_4400, 32'h0, 32'h0});
    vq.push_back('{0, 3'd0, 32'h5555_5500, 32'h0, 32'h0});
    vq.push_back('{2, 3'd0, 32'h0, 32'h0, 32'h0});
    vq.push_back('{1, 3'd4, 32'h0, 32'h0001_0005, 32'h0});
    vq.push_back('{0, 3'd1, 32'hABCD_EF00, 32'h0, 32'h0});
    vq.push_back('{2, 3'd0, 32'h0, 32'h0011_1111, 32'h00AB_CDEF});
    vq.push_back('{1, 3'd4, 32'h0, 32'h0001_0004, 32'h0});
    vq.push_back('{1, 3'd5, 32'h0, 32'h0000_0000, 32'h0});
    vq.push_back('{1, 3'd6, 32'h0, 32'h0000_0000, 32'h0});

    foreach (vq[i]) begin
      case (vq[i].kind)
        0: wr(vq[i].addr, vq[i].data);
        1: begin
          rd(vq[i].addr, d);
          chk($sformatf("vec%0d_read", i), d, vq[i].exp_a);
        end
        default: begin
          frame(seen, l, r);
          chk($sformatf("vec%0d_valid", i), {31'h0, seen}, 32'h1);
          chk($sformatf("vec%0d_l", i), {8'h0, l}, vq[i].exp_a);
          chk($sformatf("vec%0d_r", i), {8'h0, r}, vq[i].exp_b);
        end
      endcase
    end

    // Overflow: 65 pushes into a 64-deep L FIFO; the 65th must never emerge.
    wr(3'd2, 32'h3);
    for (int i = 0; i < 65; i++) wr(3'd0, {24'(i + 1), 8'h0});
    rd(3'd4, d);
    chk("ovf_stat", d, 32'h0000_8040);
    for (int i = 0; i < 64; i++) wr(3'd1, {24'(i + 1), 8'h0});
    for (int i = 0; i < 64; i++) begin
      frame(seen, l, r);
      chk($sformatf("ovf_drain%0d", i), {7'h0, seen, l}, {8'h01, 24'(i + 1)});
    end
    rd(3'd4, d);
    chk("ovf_drained_stat", d, 32'h0000_8000);
    frame(seen, l, r);
    chk("ovf_no65", {7'h0, seen, l}, 32'h0100_0000);

    // fill_req threshold behaviour.
    wr(3'd2, 32'h3);
    wr(3'd3, 32'h8);
    for (int i = 0; i < 7; i++) wr(3'd0, 32'h0000_0100);
    @(negedge clk);
    chk("fill_lvl7", {31'h0, fill_req}, 32'h1);
    wr(3'd0, 32'h0000_0100);
    @(negedge clk);
    chk("fill_lvl8", {31'h0, fill_req}, 32'h0);
    wr(3'd3, 32'h9);
    @(negedge clk);
    chk("fill_thr9", {31'h0, fill_req}, 32'h1);
    wr(3'd2, 32'h0);
    @(negedge clk);
    chk("fill_disabled", {31'h0, fill_req}, 32'h0);
    wr(3'd2, 32'h1);
    wr(3'd3, 32'h0);
    @(negedge clk);
    chk("fill_thr0", {31'h0, fill_req}, 32'h0);

    // Push into full L FIFO on the exact cycle a tick pops it.
    wr(3'd2, 32'h3);
    for (int i = 0; i < 64; i++) wr(3'd0, {24'(24'h100 + i), 8'h0});
    wr(3'd1, 32'h7777_7700);
    lrck = 1'b1;
    @(negedge clk);
    @(negedge clk);
    write = 1'b1; address = 3'd0; datain = 32'h9999_9900;
    @(negedge clk);
    write = 1'b0;
    chk("full_tick_out", {7'h0, sample_valid, lsound_out}, 32'h0100_0100);
    lrck = 1'b0;
    repeat (4) @(negedge clk);
    rd(3'd4, d);
    chk("full_tick_stat", d, 32'h0000_0040);
    wr(3'd0, 32'h8888_8800);
    rd(3'd4, d);
    chk("full_ovf_stat", d, 32'h0000_8040);
    frame(seen, l, r);
    chk("full_under", {7'h0, seen, l}, 32'h0100_0000);
    rd(3'd4, d);
    chk("full_under_stat", d, 32'h0001_8040);
    wr(3'd2, 32'h3);
    rd(3'd4, d);
    chk("flush_stat_l", d, 32'h0);
    rd(3'd5, d);
    chk("flush_stat_r", d, 32'h0);

    // Asynchronous reset in mid-stream.
    wr(3'd0, 32'h0ABC_DE00);
    wr(3'd1, 32'h0FED_CB00);
    frame(seen, l, r);
    chk("pre_reset_out", {8'h0, lsound_out}, 32'h000A_BCDE);
    wr(3'd0, 32'h0101_0100);
    rd(3'd4, d);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_l", {8'h0, lsound_out}, 32'h0);
    chk("async_rst_r", {8'h0, rsound_out}, 32'h0);
    chk("async_rst_dataout", dataout, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    rd(3'd4, d);
    chk("post_rst_stat_l", d, 32'h0);
    rd(3'd5, d);
    chk("post_rst_stat_r", d, 32'h0);
    frame(seen, l, r);
    chk("post_rst_tick_disabled", {31'h0, seen}, 32'h0);

    // Randomized run against the queue model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      int unsigned sel;
      logic [23:0] s;
      sel = $urandom_range(0, 99);
      s = 24'($urandom());
      if (sel < 30) begin
        wr(3'd0, {s, 8'($urandom())});
        if (lq.size() < 64) lq.push_back(s); else movf = 1;
      end else if (sel < 60) begin
        wr(3'd1, {s, 8'($urandom())});
        if (rq.size() < 64) rq.push_back(s); else movf = 1;
      end else if (sel < 65) begin
        bit en, fl;
        en = ($urandom_range(0, 3) != 0);
        fl = ($urandom_range(0, 5) == 0);
        wr(3'd2, {30'($urandom()), fl, en});
        men = en;
        if (fl) begin
          lq.delete(); rq.delete(); movf = 0; muf = '0;
        end
      end else if (sel < 68) begin
        logic [6:0] t;
        t = 7'($urandom_range(0, 70));
        wr(3'd3, {25'($urandom()), t});
        mthr = t;
      end else if (sel < 88) begin
        bit          ev;
        logic [23:0] el, er;
        frame(seen, l, r);
        ev = men; el = '0; er = '0;
        if (men) begin
          if (lq.size() > 0 && rq.size() > 0) begin
            el = lq.pop_front(); er = rq.pop_front();
          end else if (muf != 16'hFFFF) begin
            muf++;
          end
        end
        chk($sformatf("rnd%0d_valid", n), {31'h0, seen}, {31'h0, ev});
        if (ev) begin
          chk($sformatf("rnd%0d_l", n), {8'h0, l}, {8'h0, el});
          chk($sformatf("rnd%0d_r", n), {8'h0, r}, {8'h0, er});
        end
      end else if (sel < 94) begin
        rd(3'd4, d);
        chk($sformatf("rnd%0d_stat_l", n), d, model_stat_l());
      end else begin
        rd(3'd5, d);
        chk($sformatf("rnd%0d_stat_r", n), d, 32'(rq.size()));
      end
      @(negedge clk);
      chk($sformatf("rnd%0d_fill", n), {31'h0, fill_req},
          {31'h0, men && (lq.size() < int'(mthr))});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
